// File: rtl/piece_position_ctrl.sv
// rtl/piece_position_ctrl.sv - single-cell falling block position controller (optional HARD_DROP_EN)
module piece_position_ctrl #(
  parameter int SPAWN_COL = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [159:0] screen,
  input  logic         btn_left,
  input  logic         btn_right,
  input  logic         btn_drop,
  input  logic         grav_tick,
  output logic [3:0]   hor_block,
  output logic [3:0]   vert_block,
  output logic         lock_valid,
  input  logic         lock_ready,
  output logic         game_over
);

  localparam logic [2:0] S_SPAWN = 3'd0;
  localparam logic [2:0] S_FALL  = 3'd1;
  localparam logic [2:0] S_LOCK  = 3'd2;
  localparam logic [2:0] S_OVER  = 3'd3;
`ifdef HARD_DROP_EN
  localparam logic [2:0] S_DROP  = 3'd4;
`endif

  localparam logic [3:0] SPAWN_HOR = SPAWN_COL[3:0];

  logic [2:0] r_state;
  logic [3:0] r_hor;
  logic [3:0] r_vert;
  logic       r_lock_valid;
  logic       r_game_over;

  // Occupancy of the block's own row and the row beneath it
  logic [7:0] w_cur_base;
  logic [7:0] w_next_base;
  logic [9:0] w_cur_row;
  logic [9:0] w_next_row;
  logic [3:0] w_hor_dec;
  logic [3:0] w_hor_inc;
  logic       w_landed;
  logic       w_left_ok;
  logic       w_right_ok;
  logic       w_spawn_blocked;

  assign w_cur_base  = {4'd0, r_vert} * 8'd10;
  // On the bottom row there is no row beneath; reuse the current base so the
  // part-select stays in range (the landing test ignores it there anyway).
  assign w_next_base = (r_vert == 4'd15) ? w_cur_base : w_cur_base + 8'd10;
  assign w_cur_row   = screen[w_cur_base +: 10];
  assign w_next_row  = screen[w_next_base +: 10];

  // Saturated neighbour columns keep the bit-selects in range at the walls
  assign w_hor_dec   = (r_hor == 4'd0) ? 4'd0 : r_hor - 4'd1;
  assign w_hor_inc   = (r_hor == 4'd9) ? 4'd9 : r_hor + 4'd1;

  assign w_landed        = (r_vert == 4'd15) || w_next_row[r_hor];
  assign w_left_ok       = (r_hor != 4'd0) && !w_cur_row[w_hor_dec];
  assign w_right_ok      = (r_hor != 4'd9) && !w_cur_row[w_hor_inc];
  assign w_spawn_blocked = screen[SPAWN_COL];

`ifdef HARD_DROP_EN
`else
  logic w_unused_drop;
  assign w_unused_drop = btn_drop;
`endif

  // Block state machine: spawn, player/gravity motion, lock handshake, game over
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_SPAWN;
      r_hor        <= SPAWN_HOR;
      r_vert       <= 4'd0;
      r_lock_valid <= 1'b0;
      r_game_over  <= 1'b0;
    end else begin
      case (r_state)
        S_SPAWN: begin
          r_hor  <= SPAWN_HOR;
          r_vert <= 4'd0;
          if (w_spawn_blocked) begin
            r_state     <= S_OVER;
            r_game_over <= 1'b1;
          end else begin
            r_state <= S_FALL;
          end
        end
        S_FALL: begin
          // Gravity wins over any same-cycle horizontal request, which is dropped
          if (grav_tick) begin
            if (w_landed) begin
              r_state      <= S_LOCK;
              r_lock_valid <= 1'b1;
            end else begin
              r_vert <= r_vert + 4'd1;
            end
          end
`ifdef HARD_DROP_EN
          else if (btn_drop) begin
            r_state <= S_DROP;
          end
`endif
          else if (btn_left && !btn_right) begin
            if (w_left_ok) r_hor <= w_hor_dec;
          end else if (btn_right && !btn_left) begin
            if (w_right_ok) r_hor <= w_hor_inc;
          end
        end
`ifdef HARD_DROP_EN
        S_DROP: begin
          if (w_landed) begin
            r_state      <= S_LOCK;
            r_lock_valid <= 1'b1;
          end else begin
            r_vert <= r_vert + 4'd1;
          end
        end
`endif
        S_LOCK: begin
          if (lock_ready) begin
            r_state      <= S_SPAWN;
            r_lock_valid <= 1'b0;
          end
        end
        S_OVER: begin
          r_state <= S_OVER;
        end
        default: begin
          r_state      <= S_SPAWN;
          r_lock_valid <= 1'b0;
          r_game_over  <= 1'b0;
        end
      endcase
    end
  end

  assign hor_block  = r_hor;
  assign vert_block = r_vert;
  assign lock_valid = r_lock_valid;
  assign game_over  = r_game_over;

endmodule

// File: tb/tb_piece_position_ctrl.sv
// tb/tb_piece_position_ctrl.sv - directed bench for piece_position_ctrl
module tb_piece_position_ctrl;

  logic         clk = 1'b0;
  logic         rst;
  logic [159:0] screen;
  logic         btn_left;
  logic         btn_right;
  logic         btn_drop;
  logic         grav_tick;
  logic [3:0]   hor_block;
  logic [3:0]   vert_block;
  logic         lock_valid;
  logic         lock_ready;
  logic         game_over;

  int checks   = 0;
  int failures = 0;

  piece_position_ctrl #(.SPAWN_COL(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .screen     (screen),
    .btn_left   (btn_left),
    .btn_right  (btn_right),
    .btn_drop   (btn_drop),
    .grav_tick  (grav_tick),
    .hor_block  (hor_block),
    .vert_block (vert_block),
    .lock_valid (lock_valid),
    .lock_ready (lock_ready),
    .game_over  (game_over)
  );

  always #5 clk = ~clk;

  // One clock of stimulus; returns at the following falling edge
  task automatic step(input logic l, input logic r, input logic d, input logic g);
    btn_left  = l;
    btn_right = r;
    btn_drop  = d;
    grav_tick = g;
    @(negedge clk);
    btn_left  = 1'b0;
    btn_right = 1'b0;
    btn_drop  = 1'b0;
    grav_tick = 1'b0;
  endtask

  // Reset, load playfield, release, and let the spawn edge happen
  task automatic restart(input logic [159:0] scr);
    rst    = 1'b1;
    screen = scr;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset;
    checks++;
    if ({hor_block, vert_block, lock_valid, game_over} !== {4'd4, 4'd0, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL reset_state got h=%0d v=%0d lv=%b go=%b want h=4 v=0 lv=0 go=0",
               hor_block, vert_block, lock_valid, game_over);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({hor_block, vert_block} !== {4'd4, 4'd0}) begin
      failures++;
      $display("FAIL spawn_pos got (%0d,%0d) want (4,0)", hor_block, vert_block);
    end
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'b1);
    #1 rst = 1'b1;
    #1;
    checks++;
    if ({hor_block, vert_block} !== {4'd4, 4'd0}) begin
      failures++;
      $display("FAIL async_reset_fall got (%0d,%0d) want (4,0)", hor_block, vert_block);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 16; i++) step(1'b0, 1'b0, 1'b0, 1'b1);
    checks++;
    if (lock_valid !== 1'b1) begin
      failures++;
      $display("FAIL reach_lock got lv=%b want 1", lock_valid);
    end
    #1 rst = 1'b1;
    #1;
    checks++;
    if ({lock_valid, hor_block, vert_block} !== {1'b0, 4'd4, 4'd0}) begin
      failures++;
      $display("FAIL async_reset_lock got lv=%b (%0d,%0d) want lv=0 (4,0)",
               lock_valid, hor_block, vert_block);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_gravity;
    restart('0);
    for (int i = 0; i < 15; i++) step(1'b0, 1'b0, 1'b0, 1'b1);
    checks++;
    if ({hor_block, vert_block, lock_valid} !== {4'd4, 4'd15, 1'b0}) begin
      failures++;
      $display("FAIL grav_15 got (%0d,%0d) lv=%b want (4,15) lv=0", hor_block, vert_block, lock_valid);
    end
    step(1'b0, 1'b0, 1'b0, 1'b1);
    checks++;
    if ({hor_block, vert_block, lock_valid} !== {4'd4, 4'd15, 1'b1}) begin
      failures++;
      $display("FAIL grav_16_lock got (%0d,%0d) lv=%b want (4,15) lv=1", hor_block, vert_block, lock_valid);
    end
  endtask

  task automatic test_lock_wait;
    int bad;
    restart('0);
    for (int i = 0; i < 16; i++) step(1'b0, 1'b0, 1'b0, 1'b1);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      step(i[0], ~i[0], 1'b1, 1'b1);
      if ({hor_block, vert_block, lock_valid} !== {4'd4, 4'd15, 1'b1}) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL lock_hold unstable_cycles=%0d want 0 (last (%0d,%0d) lv=%b)",
               bad, hor_block, vert_block, lock_valid);
    end
    lock_ready = 1'b1;
    @(negedge clk);
    lock_ready = 1'b0;
    checks++;
    if (lock_valid !== 1'b0) begin
      failures++;
      $display("FAIL lock_accept got lv=%b want 0", lock_valid);
    end
    @(negedge clk);
    checks++;
    if ({hor_block, vert_block, lock_valid} !== {4'd4, 4'd0, 1'b0}) begin
      failures++;
      $display("FAIL respawn got (%0d,%0d) lv=%b want (4,0) lv=0", hor_block, vert_block, lock_valid);
    end
  endtask

  task automatic test_walls;
    logic [159:0] s;
    restart('0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
    checks++;
    if ({hor_block, vert_block} !== {4'd0, 4'd5}) begin
      failures++;
      $display("FAIL walk_left got (%0d,%0d) want (0,5)", hor_block, vert_block);
    end
    step(1'b1, 1'b0, 1'b0, 1'b0);
    checks++;
    if ({hor_block, vert_block} !== {4'd0, 4'd5}) begin
      failures++;
      $display("FAIL left_wall got (%0d,%0d) want (0,5)", hor_block, vert_block);
    end
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'b0, 1'b0);
    checks++;
    if ({hor_block, vert_block} !== {4'd9, 4'd5}) begin
      failures++;
      $display("FAIL right_wall got (%0d,%0d) want (9,5)", hor_block, vert_block);
    end
    s = '0;
    s[5*10+3] = 1'b1;
    restart(s);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    checks++;
    if ({hor_block, vert_block} !== {4'd4, 4'd5}) begin
      failures++;
      $display("FAIL left_blocked got (%0d,%0d) want (4,5)", hor_block, vert_block);
    end
    step(1'b0, 1'b1, 1'b0, 1'b0);
    checks++;
    if ({hor_block, vert_block} !== {4'd5, 4'd5}) begin
      failures++;
      $display("FAIL right_free got (%0d,%0d) want (5,5)", hor_block, vert_block);
    end
  endtask

  task automatic test_priority;
    restart('0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b1);
    checks++;
    if ({hor_block, vert_block} !== {4'd4, 4'd3}) begin
      failures++;
      $display("FAIL grav_over_right got (%0d,%0d) want (4,3)", hor_block, vert_block);
    end
    step(1'b1, 1'b1, 1'b0, 1'b0);
    checks++;
    if ({hor_block, vert_block} !== {4'd4, 4'd3}) begin
      failures++;
      $display("FAIL left_and_right got (%0d,%0d) want (4,3)", hor_block, vert_block);
    end
    step(1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if ({hor_block, vert_block} !== {4'd4, 4'd3}) begin
      failures++;
      $display("FAIL no_queue got (%0d,%0d) want (4,3)", hor_block, vert_block);
    end
  endtask

  task automatic test_land_on_block;
    logic [159:0] s;
    s = '0;
    s[10*10+4] = 1'b1;
    restart(s);
    for (int i = 0; i < 9; i++) step(1'b0, 1'b0, 1'b0, 1'b1);
    checks++;
    if ({vert_block, lock_valid} !== {4'd9, 1'b0}) begin
      failures++;
      $display("FAIL above_stack got v=%0d lv=%b want v=9 lv=0", vert_block, lock_valid);
    end
    step(1'b0, 1'b0, 1'b0, 1'b1);
    checks++;
    if ({hor_block, vert_block, lock_valid} !== {4'd4, 4'd9, 1'b1}) begin
      failures++;
      $display("FAIL land_on_stack got (%0d,%0d) lv=%b want (4,9) lv=1", hor_block, vert_block, lock_valid);
    end
  endtask

  task automatic test_game_over;
    logic [159:0] s;
    s = '0;
    s[4] = 1'b1;
    restart(s);
    checks++;
    if ({game_over, lock_valid, hor_block, vert_block} !== {1'b1, 1'b0, 4'd4, 4'd0}) begin
      failures++;
      $display("FAIL game_over_set got go=%b lv=%b (%0d,%0d) want go=1 lv=0 (4,0)",
               game_over, lock_valid, hor_block, vert_block);
    end
    lock_ready = 1'b1;
    step(1'b1, 1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    lock_ready = 1'b0;
    checks++;
    if ({game_over, lock_valid, hor_block, vert_block} !== {1'b1, 1'b0, 4'd4, 4'd0}) begin
      failures++;
      $display("FAIL game_over_hold got go=%b lv=%b (%0d,%0d) want go=1 lv=0 (4,0)",
               game_over, lock_valid, hor_block, vert_block);
    end
    #1 rst = 1'b1;
    #1;
    checks++;
    if (game_over !== 1'b0) begin
      failures++;
      $display("FAIL game_over_clear got go=%b want 0", game_over);
    end
    screen = '0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_drop;
    restart('0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
`ifdef HARD_DROP_EN
    btn_left = 1'b1;
    for (int i = 0; i < 15; i++) @(negedge clk);
    btn_left = 1'b0;
    checks++;
    if ({hor_block, vert_block, lock_valid} !== {4'd4, 4'd15, 1'b0}) begin
      failures++;
      $display("FAIL drop_15 got (%0d,%0d) lv=%b want (4,15) lv=0", hor_block, vert_block, lock_valid);
    end
    @(negedge clk);
    checks++;
    if ({hor_block, vert_block, lock_valid} !== {4'd4, 4'd15, 1'b1}) begin
      failures++;
      $display("FAIL drop_lock got (%0d,%0d) lv=%b want (4,15) lv=1", hor_block, vert_block, lock_valid);
    end
`else
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if ({hor_block, vert_block, lock_valid} !== {4'd4, 4'd0, 1'b0}) begin
      failures++;
      $display("FAIL drop_ignored got (%0d,%0d) lv=%b want (4,0) lv=0", hor_block, vert_block, lock_valid);
    end
    step(1'b1, 1'b0, 1'b0, 1'b0);
    checks++;
    if ({hor_block, vert_block} !== {4'd3, 4'd0}) begin
      failures++;
      $display("FAIL still_falling got (%0d,%0d) want (3,0)", hor_block, vert_block);
    end
`endif
  endtask

  initial begin
    rst        = 1'b1;
    screen     = '0;
    btn_left   = 1'b0;
    btn_right  = 1'b0;
    btn_drop   = 1'b0;
    grav_tick  = 1'b0;
    lock_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_gravity();
    test_lock_wait();
    test_walls();
    test_priority();
    test_land_on_block();
    test_game_over();
    test_drop();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/piece_position_ctrl.md
PIECE_POSITION_CTRL -- requirements
Module: piece_position_ctrl

Interface
REQ-001 SHALL have parameter: SPAWN_COL, default 4, column (0-9) where each new block appears in row 0.
REQ-002 SHALL have port: clk  input  1  single system clock, all state changes on rising edge.
REQ-003 SHALL have port: rst  input  1  asynchronous active-high reset.
REQ-004 SHALL have port: screen  input  160  playfield occupancy, row-major, bit (row*10+col), row 0 at top, 1 = occupied; 16 rows x 10 columns.
REQ-005 SHALL have port: btn_left  input  1  single-cycle move-left request pulse.
REQ-006 SHALL have port: btn_right  input  1  single-cycle move-right request pulse.
REQ-007 SHALL have port: btn_drop  input  1  single-cycle drop request pulse.
REQ-008 SHALL have port: grav_tick  input  1  single-cycle gravity pulse.
REQ-009 SHALL have port: hor_block  output  4  current block column, 0-9.
REQ-010 SHALL have port: vert_block  output  4  current block row, 0-15.
REQ-011 SHALL have port: lock_valid  output  1  block landed; hor_block/vert_block give the cell to commit into screen.
REQ-012 SHALL have port: lock_ready  input  1  consumer accepted the lock.
REQ-013 SHALL have port: game_over  output  1  spawn cell blocked; play halted.

Function
REQ-014 SHALL implement FSM states SPAWN, FALL, LOCK, OVER, plus DROP only when HARD_DROP_EN is defined.
REQ-015 SPAWN: SHALL load hor_block=SPAWN_COL, vert_block=0; next cycle FALL if screen[0][SPAWN_COL]=0, else OVER.
REQ-016 FALL, descent event (grav_tick=1): if vert_block=15 or screen[vert_block+1][hor_block]=1 SHALL go to LOCK with position unchanged, else vert_block+1.
REQ-017 FALL, no descent event: btn_left SHALL decrement hor_block only if hor_block>0 and screen[vert_block][hor_block-1]=0, else position held.
REQ-018 FALL, no descent event: btn_right SHALL increment hor_block only if hor_block<9 and screen[vert_block][hor_block+1]=0, else position held.
REQ-019 FALL, btn_left and btn_right both 1 in the same cycle: SHALL not move.
REQ-020 FALL, descent event coincident with btn_left/btn_right: descent SHALL take priority; the horizontal request SHALL be discarded, not queued.
REQ-021 Every move SHALL take effect on the clock edge that samples the request (one-cycle latency); at most one cell of movement per cycle.
REQ-022 LOCK: lock_valid SHALL be 1 with hor_block/vert_block stable; all button and gravity inputs ignored; on lock_valid&&lock_ready SHALL go to SPAWN next cycle.
REQ-023 LOCK with lock_ready held low: SHALL wait indefinitely.
REQ-024 OVER: game_over SHALL be 1 and position held; all inputs ignored until rst.
REQ-025 lock_valid SHALL be 1 only in LOCK; game_over only in OVER; both registered outputs.
REQ-026 Column/row arithmetic SHALL never wrap: no decrement below 0, no increment above 9 (column) or 15 (row).

Reset
REQ-027 rst=1 SHALL immediately force state SPAWN, hor_block=SPAWN_COL, vert_block=0, lock_valid=0, game_over=0.
REQ-028 Reset asserted mid-FALL, mid-LOCK or mid-DROP SHALL abandon the current block without issuing a lock.
REQ-029 The first rising edge after rst deasserts SHALL execute SPAWN.

Configuration
REQ-030 Macro HARD_DROP_EN defined: btn_drop in FALL SHALL enter DROP. DROP SHALL descend one row per cycle, ignore all other inputs, and go to LOCK under the REQ-016 landing condition.
REQ-031 Macro HARD_DROP_EN undefined: btn_drop SHALL be ignored in every state, and no DROP state SHALL exist.

Verification
REQ-032 Empty screen, reset release -> hor_block=4, vert_block=0, state FALL after 1 cycle; 15 grav_tick pulses -> vert_block=15; 16th pulse -> lock_valid=1 at (4,15).
REQ-033 Empty screen, block at (0,5), btn_left -> stays col 0; cell (5,3) occupied, block at (4,5), btn_left -> stays col 4; btn_right -> col 5.
REQ-034 Block at (4,2), grav_tick+btn_right same cycle -> (4,3), no horizontal move; btn_left+btn_right together -> no move.
REQ-035 lock_valid=1 with lock_ready=0 for 10 cycles -> position and lock_valid stable; lock_ready=1 -> SPAWN next cycle, then (4,0).
REQ-036 Cell (0,4) occupied at spawn -> game_over=1; buttons and ticks ignored; rst -> game_over=0.
REQ-037 HARD_DROP_EN, empty column 4, btn_drop at (4,0) -> vert_block reaches 15 in 15 cycles, then lock_valid=1; without the macro -> no movement.
